// File: rtl/gte_orgb_sched.sv
// Sequencer for the shared 16-to-5 colour clamp: converts IR1..IR3 into a packed
// ORGB value one component per cycle and arbitrates ORGB reads against conversions.
//
// state | meaning
// IDLE  | no conversion pending; ORGB reads may be granted
// CV_R  | clamp driven with IR1 snapshot, result captured into shadow R
// CV_G  | clamp driven with IR2 snapshot, result captured into shadow G
// CV_B  | clamp driven with IR3 snapshot, ORGB committed at end of cycle
module gte_orgb_sched #(
    parameter int IR_W  = 16,
    parameter int OUT_W = 5
) (
    input  logic               i_clk,
    input  logic               i_nRst,
    input  logic               i_irWrite,
    input  logic [IR_W-1:0]    i_ir1,
    input  logic [IR_W-1:0]    i_ir2,
    input  logic [IR_W-1:0]    i_ir3,
    output logic [IR_W-1:0]    o_clampIn,
    input  logic [OUT_W-1:0]   i_clampOut,
    input  logic               i_rdReq,
    output logic               o_rdAck,
    output logic [3*OUT_W-1:0] o_rdData,
    output logic [3*OUT_W-1:0] o_orgb,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CV_R = 2'd1,
        CV_G = 2'd2,
        CV_B = 2'd3
    } stateE;

    stateE state;
    stateE stateNext;

    logic [IR_W-1:0]  ir1s;
    logic [IR_W-1:0]  ir2s;
    logic [IR_W-1:0]  ir3s;
    logic [IR_W-1:0]  clampHold;
    logic [OUT_W-1:0] shadowR;
    logic [OUT_W-1:0] shadowG;

    logic loadR;
    logic loadG;
    logic commit;
    logic rdGrant;

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A new write always restarts from red, abandoning any partial conversion.
    always_comb begin
        stateNext = state;
        if (i_irWrite) begin
            stateNext = CV_R;
        end else begin
            case (state)
                CV_R:    stateNext = CV_G;
                CV_G:    stateNext = CV_B;
                CV_B:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy    = (state != IDLE);
        o_clampIn = clampHold;
        loadR     = 1'b0;
        loadG     = 1'b0;
        commit    = 1'b0;
        case (state)
            CV_R: begin
                o_clampIn = ir1s;
                loadR     = ~i_irWrite;
            end
            CV_G: begin
                o_clampIn = ir2s;
                loadG     = ~i_irWrite;
            end
            CV_B: begin
                o_clampIn = ir3s;
                commit    = ~i_irWrite;
            end
            default: o_clampIn = clampHold;
        endcase
        rdGrant = (state == IDLE) && i_rdReq && !i_irWrite && !o_rdAck;
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            ir1s <= '0;
            ir2s <= '0;
            ir3s <= '0;
        end else if (i_irWrite) begin
            ir1s <= i_ir1;
            ir2s <= i_ir2;
            ir3s <= i_ir3;
        end
    end

    // clampHold keeps the operand stable while idle so the clamp input does not toggle.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            clampHold <= '0;
            shadowR   <= '0;
            shadowG   <= '0;
            o_orgb    <= '0;
        end else begin
            if (o_busy) begin
                clampHold <= o_clampIn;
            end
            if (loadR) begin
                shadowR <= i_clampOut;
            end
            if (loadG) begin
                shadowG <= i_clampOut;
            end
            if (commit) begin
                o_orgb <= {i_clampOut, shadowG, shadowR};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            o_rdAck  <= 1'b0;
            o_rdData <= '0;
        end else begin
            o_rdAck <= rdGrant;
            if (rdGrant) begin
                o_rdData <= o_orgb;
            end
        end
    end

endmodule

// File: tb/tb_gte_orgb_sched.sv
// Self-checking bench for gte_orgb_sched: vector table through the conversion/read
// path, read-data scoreboard, and hand-written restart, collision and reset sequences.
module tb_gte_orgb_sched;

    logic        i_clk = 1'b0;
    logic        i_nRst = 1'b0;
    logic        i_irWrite = 1'b0;
    logic [15:0] i_ir1 = '0;
    logic [15:0] i_ir2 = '0;
    logic [15:0] i_ir3 = '0;
    logic [15:0] o_clampIn;
    logic [4:0]  i_clampOut;
    logic        i_rdReq = 1'b0;
    logic        o_rdAck;
    logic [14:0] o_rdData;
    logic [14:0] o_orgb;
    logic        o_busy;

    gte_orgb_sched #(.IR_W(16), .OUT_W(5)) dut (
        .i_clk      (i_clk),
        .i_nRst     (i_nRst),
        .i_irWrite  (i_irWrite),
        .i_ir1      (i_ir1),
        .i_ir2      (i_ir2),
        .i_ir3      (i_ir3),
        .o_clampIn  (o_clampIn),
        .i_clampOut (i_clampOut),
        .i_rdReq    (i_rdReq),
        .o_rdAck    (o_rdAck),
        .o_rdData   (o_rdData),
        .o_orgb     (o_orgb),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // External clamp model: signed divide by 128, saturate to 0..31.
    function automatic logic [4:0] clampRef(input logic [15:0] v);
        logic signed [15:0] q;
        q = $signed(v) >>> 7;
        if (q < 0) return 5'd0;
        else if (q > 31) return 5'd31;
        else return q[4:0];
    endfunction

    always_comb i_clampOut = clampRef(o_clampIn);

    typedef struct {
        logic [15:0] ir1;
        logic [15:0] ir2;
        logic [15:0] ir3;
        logic [14:0] orgb;
    } vecT;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [14:0] sbQ[$];
    logic        prevAck = 1'b0;
    logic [14:0] sbExp;
    logic [14:0] expOrgb = '0;
    vecT         vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Read-data scoreboard: every ack must match the oldest expected read.
    always @(posedge i_clk) begin
        #1;
        if (o_rdAck) begin
            check("ack_not_back_to_back", 32'(prevAck), 32'd0);
            if (sbQ.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("FAIL unexpected_ack: got ack with data 0x%0h, expected no ack", o_rdData);
            end else begin
                sbExp = sbQ.pop_front();
                check("sb_rd_data", 32'(o_rdData), 32'(sbExp));
            end
        end
        prevAck = o_rdAck;
    end

    initial begin
        vecs[0] = '{16'h0F80, 16'h1000, 16'h8000, 15'h03FF};
        vecs[1] = '{16'h0380, 16'h0100, 16'h0000, 15'h0047};
        vecs[2] = '{16'h0000, 16'h0000, 16'h0F80, 15'h7C00};
        vecs[3] = '{16'hFFFF, 16'h007F, 16'h0080, 15'h0400};
        vecs[4] = '{16'h0C00, 16'h7FFF, 16'h0A00, 15'h53F8};
        vecs[5] = '{16'h0FFF, 16'h0F7F, 16'h0180, 15'h0FDF};

        #3;
        check("rst_orgb",    32'(o_orgb),    32'd0);
        check("rst_busy",    32'(o_busy),    32'd0);
        check("rst_ack",     32'(o_rdAck),   32'd0);
        check("rst_rddata",  32'(o_rdData),  32'd0);
        check("rst_clampin", 32'(o_clampIn), 32'd0);
        #10;
        i_nRst = 1'b1;
        step();

        // Vector table: write, read requested while busy, ack after commit.
        for (int k = 0; k < 6; k++) begin
            i_ir1 = vecs[k].ir1;
            i_ir2 = vecs[k].ir2;
            i_ir3 = vecs[k].ir3;
            i_irWrite = 1'b1;
            sbQ.push_back(vecs[k].orgb);
            step();
            i_irWrite = 1'b0;
            i_rdReq = 1'b1;
            check("vec_busy_r",    32'(o_busy),    32'd1);
            check("vec_clamp_r",   32'(o_clampIn), 32'(vecs[k].ir1));
            check("vec_orgb_hold", 32'(o_orgb),    32'(expOrgb));
            step();
            check("vec_clamp_g",   32'(o_clampIn), 32'(vecs[k].ir2));
            check("vec_ack_busy",  32'(o_rdAck),   32'd0);
            step();
            check("vec_busy_b",    32'(o_busy),    32'd1);
            check("vec_clamp_b",   32'(o_clampIn), 32'(vecs[k].ir3));
            check("vec_orgb_hold", 32'(o_orgb),    32'(expOrgb));
            step();
            expOrgb = vecs[k].orgb;
            check("vec_busy_done", 32'(o_busy),    32'd0);
            check("vec_orgb",      32'(o_orgb),    32'(expOrgb));
            check("vec_ack_early", 32'(o_rdAck),   32'd0);
            check("vec_clamp_idle",32'(o_clampIn), 32'(vecs[k].ir3));
            step();
            i_rdReq = 1'b0;
            check("vec_ack",       32'(o_rdAck),   32'd1);
            check("vec_rddata",    32'(o_rdData),  32'(expOrgb));
            step();
            check("vec_ack_drop",  32'(o_rdAck),   32'd0);
        end

        // Restart: write A then write B two edges later; A never commits.
        i_ir1 = 16'h0100; i_ir2 = 16'h0200; i_ir3 = 16'h0300;
        i_irWrite = 1'b1;
        step();
        i_irWrite = 1'b0;
        check("rs_clamp_a1", 32'(o_clampIn), 32'h0100);
        step();
        check("rs_clamp_a2", 32'(o_clampIn), 32'h0200);
        i_ir1 = 16'h0280; i_ir2 = 16'h0500; i_ir3 = 16'h0780;
        i_irWrite = 1'b1;
        i_rdReq = 1'b1;
        sbQ.push_back(15'h3D45);
        step();
        i_irWrite = 1'b0;
        check("rs_clamp_b1", 32'(o_clampIn), 32'h0280);
        check("rs_busy",     32'(o_busy),    32'd1);
        check("rs_orgb_old", 32'(o_orgb),    32'(expOrgb));
        step();
        check("rs_clamp_b2", 32'(o_clampIn), 32'h0500);
        check("rs_orgb_old", 32'(o_orgb),    32'(expOrgb));
        step();
        check("rs_clamp_b3", 32'(o_clampIn), 32'h0780);
        check("rs_orgb_old", 32'(o_orgb),    32'(expOrgb));
        check("rs_ack_busy", 32'(o_rdAck),   32'd0);
        step();
        expOrgb = 15'h3D45;
        check("rs_orgb_b",   32'(o_orgb),    32'(expOrgb));
        check("rs_busy_end", 32'(o_busy),    32'd0);
        check("rs_ack_early",32'(o_rdAck),   32'd0);
        step();
        i_rdReq = 1'b0;
        check("rs_ack",      32'(o_rdAck),   32'd1);
        check("rs_rddata",   32'(o_rdData),  32'(expOrgb));
        step();

        // Write and read in the same idle cycle: write wins, ack carries new value.
        i_ir1 = 16'h0F80; i_ir2 = 16'h0000; i_ir3 = 16'h0080;
        i_irWrite = 1'b1;
        i_rdReq = 1'b1;
        sbQ.push_back(15'h041F);
        step();
        i_irWrite = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("col_no_ack", 32'(o_rdAck), 32'd0);
            step();
        end
        expOrgb = 15'h041F;
        check("col_orgb",   32'(o_orgb),   32'(expOrgb));
        check("col_no_ack", 32'(o_rdAck),  32'd0);
        step();
        i_rdReq = 1'b0;
        check("col_ack",    32'(o_rdAck),  32'd1);
        check("col_rddata", 32'(o_rdData), 32'(expOrgb));
        step();

        // Back-to-back writes: stays in CV_R, no commit, read stalls.
        i_rdReq = 1'b1;
        for (int w = 0; w < 4; w++) begin
            i_ir1 = 16'((w + 1) * 256);
            i_ir2 = (w == 3) ? 16'h0F80 : 16'h0100;
            i_ir3 = 16'h0000;
            i_irWrite = 1'b1;
            if (w == 3) sbQ.push_back(15'h03E8);
            step();
            check("b2b_busy",   32'(o_busy),    32'd1);
            check("b2b_clamp",  32'(o_clampIn), 32'((w + 1) * 256));
            check("b2b_orgb",   32'(o_orgb),    32'(expOrgb));
            check("b2b_no_ack", 32'(o_rdAck),   32'd0);
        end
        i_irWrite = 1'b0;
        step();
        check("b2b_no_ack", 32'(o_rdAck), 32'd0);
        step();
        check("b2b_no_ack", 32'(o_rdAck), 32'd0);
        step();
        expOrgb = 15'h03E8;
        check("b2b_orgb_commit", 32'(o_orgb),  32'(expOrgb));
        check("b2b_no_ack",      32'(o_rdAck), 32'd0);
        step();
        i_rdReq = 1'b0;
        check("b2b_ack",    32'(o_rdAck),  32'd1);
        check("b2b_rddata", 32'(o_rdData), 32'(expOrgb));
        step();

        // Held request while idle: ack on alternate cycles, stable data.
        repeat (3) sbQ.push_back(expOrgb);
        i_rdReq = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            check("held_ack_pattern", 32'(o_rdAck),  32'(e % 2));
            check("held_rddata",      32'(o_rdData), 32'(expOrgb));
        end
        i_rdReq = 1'b0;
        step();
        check("held_ack_drop", 32'(o_rdAck), 32'd0);

        // Async reset in CV_G with a pending read.
        i_ir1 = 16'h0100; i_ir2 = 16'h0100; i_ir3 = 16'h0100;
        i_irWrite = 1'b1;
        step();
        i_irWrite = 1'b0;
        i_rdReq = 1'b1;
        step();
        check("ar_busy_cvg", 32'(o_busy),    32'd1);
        check("ar_clamp_g",  32'(o_clampIn), 32'h0100);
        #2;
        i_nRst = 1'b0;
        #1;
        expOrgb = '0;
        check("ar_orgb",    32'(o_orgb),    32'd0);
        check("ar_busy",    32'(o_busy),    32'd0);
        check("ar_ack",     32'(o_rdAck),   32'd0);
        check("ar_rddata",  32'(o_rdData),  32'd0);
        check("ar_clampin", 32'(o_clampIn), 32'd0);
        i_rdReq = 1'b0;
        step();
        step();
        i_nRst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("ar_post_busy", 32'(o_busy),  32'd0);
            check("ar_post_orgb", 32'(o_orgb),  32'd0);
            check("ar_post_ack",  32'(o_rdAck), 32'd0);
        end

        check("sb_drained", 32'(sbQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
